i2s_out_serializer: RTL and testbench
=====================================

I2S_OUT_SERIALIZER -- requirements
Module: i2s_out_serializer

Interface
REQ-001 SHALL have parameter: CYC_PER_HALF_SCK, 40, clk cycles per sck half-period (>=2).
REQ-002 SHALL have parameter: BITS, 16, bits per channel word.
REQ-003 SHALL have port: clk  input  1  system clock (100 MHz), all logic on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port: en  input  1  run enable; low forces idle.
REQ-006 SHALL have port: l_data  input  BITS  left-channel sample.
REQ-007 SHALL have port: r_data  input  BITS  right-channel sample.
REQ-008 SHALL have port: in_valid  input  1  l_data/r_data pair valid.
REQ-009 SHALL have port: in_ready  output  1  holding register empty; pair accepted when in_valid & in_ready at clk edge.
REQ-010 SHALL have port: sck  output  1  I2S serial clock (master-generated).
REQ-011 SHALL have port: ws  output  1  I2S word select, 0=left, 1=right.
REQ-012 SHALL have port: sd  output  1  I2S serial data, MSB first.
REQ-013 SHALL have port: underrun  output  1  one-cycle pulse when a frame starts with holding register empty.

Function
REQ-014 SHALL implement states IDLE and RUN; IDLE->RUN on en=1, RUN->IDLE on en=0 (next edge, any point in frame).
REQ-015 In IDLE: sck=0, ws=0, sd=0, half-period counter=0, slot position=(lr=0,bit=0); holding register retained, handshake still active.
REQ-016 Holding register: one {l_data,r_data} entry; in_ready = holding empty, registered, no combinational path from in_valid.
REQ-017 In RUN: half-period counter counts 0..CYC_PER_HALF_SCK-1, wraps to 0 and toggles sck at terminal count.
REQ-018 Shift event = sck 1->0 toggle; slot position advances bit 0..BITS-1, then lr toggles and bit returns to 0.
REQ-019 Each slot lasts 2*CYC_PER_HALF_SCK clk cycles; frame = 2*BITS slots (default 2560 cycles).
REQ-020 sd and ws SHALL change only at shift events (and on IDLE->RUN entry); stable across every sck rising edge.
REQ-021 sd for slot (lr,bit) = word[lr][BITS-1-bit].
REQ-022 ws for slot (lr,bit) = lr XOR (bit==BITS-1), i.e. ws leads channel change by one bit.
REQ-023 Frame load occurs on IDLE->RUN entry and at the shift event advancing (1,BITS-1)->(0,0): 2*BITS-bit shift register loaded from holding, holding marked empty.
REQ-024 Frame load with holding empty: shift register loaded with zeros, underrun=1 for exactly that cycle.
REQ-025 No bypass: a pair accepted in the same cycle as a load with holding empty is NOT used by that frame; it goes to holding.
REQ-026 Holding full at load: in_ready=0 that cycle, rises on following edge.
REQ-027 On IDLE->RUN entry, first slot is (0,0): sd=l[BITS-1], ws=0, sck=0; first sck rise after CYC_PER_HALF_SCK cycles.
REQ-028 en deassert mid-frame discards the in-flight frame; re-entry restarts at (0,0) with a new load.

Reset
REQ-029 On rst_n=0 (any time, asynchronous): state=IDLE, sck=0, ws=0, sd=0, in_ready=1, underrun=0, holding empty, shift register=0, counters=0.
REQ-030 After rst_n release, no output change until en=1 sampled.

Verification
REQ-031 Load 16'hAAAA/16'hFFFF, en=1 -> sd bits 1010... left then sixteen 1s right, ws low 15 slots, high 16, low 1; sck period 80 cycles.
REQ-032 Back-to-back pairs 16'h1478/16'hA3B9 then 16'hCDD7/16'hBABA, in_valid held -> second accepted the cycle after first load, no underrun, frames contiguous.
REQ-033 en=1 with holding empty -> underrun pulse one cycle, sd=0 for 32 slots, ws pattern unchanged.
REQ-034 Pair 16'h0001/16'hFFFF presented in load cycle with holding empty -> underrun, zeros frame, pair sent in following frame.
REQ-035 en dropped at slot (1,7) -> next edge sck=ws=sd=0; en re-raised -> restart at (0,0) with new load.
REQ-036 rst_n pulsed low mid-frame -> all outputs at reset values immediately; in_ready=1; holding content lost.

Source files
------------

// File: rtl/i2s_out_serializer.sv
// I2S master transmitter: one-pair holding register feeding a 2*BITS shift register,
// with sck, ws and sd generated from a half-period counter and slot position.
module i2s_out_serializer #(
    parameter int CYC_PER_HALF_SCK = 40,
    parameter int BITS             = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [BITS-1:0] l_data,
    input  logic [BITS-1:0] r_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            sck,
    output logic            ws,
    output logic            sd,
    output logic            underrun
);

    localparam int CW = (CYC_PER_HALF_SCK > 1) ? $clog2(CYC_PER_HALF_SCK) : 1;
    localparam int BW = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int FW = 2 * BITS;
    localparam logic [CW-1:0] CNT_TC = CW'(CYC_PER_HALF_SCK - 1);
    localparam logic [BW-1:0] BIT_TC = BW'(BITS - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sck_q, sck_d;
    logic            lr_q, lr_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [FW-1:0]   sh_q, sh_d;
    logic [FW-1:0]   hold_q, hold_d;
    logic            full_q, full_d;
    logic            urun_q, urun_d;

    logic            accept;
    logic            tc;
    logic            shift;
    logic            load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sck_q   <= 1'b0;
            lr_q    <= 1'b0;
            bit_q   <= '0;
            sh_q    <= '0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            urun_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sck_q   <= sck_d;
            lr_q    <= lr_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            urun_q  <= urun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sck_d   = sck_q;
        lr_d    = lr_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        hold_d  = hold_q;
        full_d  = full_q;
        urun_d  = 1'b0;
        load    = 1'b0;
        accept  = in_valid & ~full_q;
        tc      = (cnt_q == CNT_TC);
        shift   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sck_d   = 1'b0;
                    lr_d    = 1'b0;
                    bit_d   = '0;
                    sh_d    = '0;
                end else begin
                    cnt_d = tc ? '0 : cnt_q + CW'(1);
                    if (tc) begin
                        sck_d = ~sck_q;
                    end
                    shift = tc & sck_q;
                    if (shift) begin
                        sh_d = sh_q << 1;
                        if (bit_q == BIT_TC) begin
                            bit_d = '0;
                            lr_d  = ~lr_q;
                            load  = lr_q;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A pair arriving in the load cycle is never bypassed into the frame.
        if (load) begin
            sh_d   = full_q ? hold_q : '0;
            urun_d = ~full_q;
        end
        full_d = (full_q & ~load) | accept;
        if (accept) begin
            hold_d = {l_data, r_data};
        end
    end

    assign in_ready = ~full_q;
    assign sck      = sck_q;
    assign ws       = lr_q ^ (bit_q == BIT_TC);
    assign sd       = sh_q[FW-1];
    assign underrun = urun_q;

endmodule

// File: tb/tb_i2s_out_serializer.sv
// Directed bench: expected (ws,sd) slots are queued as pairs are offered and
// popped at every sck rising edge.
module tb_i2s_out_serializer;

    localparam int C = 40;
    localparam int B = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [B-1:0] l_data = '0;
    logic [B-1:0] r_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         sck;
    logic         ws;
    logic         sd;
    logic         underrun;

    int           vectors = 0;
    int           miscompares = 0;
    int           ur_cnt = 0;
    int           ur0;
    int           n;
    logic         prev;
    logic         sck_prev = 1'b0;
    bit           mon_on = 1'b1;
    logic [1:0]   exp_q[$];

    i2s_out_serializer #(
        .CYC_PER_HALF_SCK(C),
        .BITS(B)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .l_data(l_data),
        .r_data(r_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .sck(sck),
        .ws(ws),
        .sd(sd),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_slots(input logic [B-1:0] l, input logic [B-1:0] r,
                              input int nslots);
        logic [B-1:0] w;
        int k;
        k = 0;
        for (int lr = 0; lr < 2; lr++) begin
            w = (lr == 1) ? r : l;
            for (int b = 0; b < B; b++) begin
                if (k < nslots) begin
                    exp_q.push_back({(lr == 1) ^ (b == B - 1), w[B-1-b]});
                end
                k++;
            end
        end
    endtask

    task automatic wait_drain(input int budget, input string tag);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Slot checker: sd/ws sampled on the falling clk after each sck rise.
    always @(negedge clk) begin
        if (sck && !sck_prev && mon_on) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sck_rise", 1, 0);
            end else begin
                check("slot_ws_sd", {30'd0, ws, sd}, {30'd0, exp_q.pop_front()});
            end
        end
        if (underrun) begin
            ur_cnt++;
        end
        sck_prev = sck;
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_outputs", {sck, ws, sd, underrun}, 4'b0000);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_quiet", {sck, ws, sd}, 3'b000);

        // AAAA / FFFF single frame, sck timing
        l_data = 16'hAAAA;
        r_data = 16'hFFFF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("t1_hold_full", in_ready, 0);
        ur0 = ur_cnt;
        push_slots(16'hAAAA, 16'hFFFF, 2 * B);
        en = 1'b1;
        @(posedge clk);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sck) break;
            n++;
        end
        check("t1_first_rise", n, C);
        check("t1_ready_after_load", in_ready, 1);
        n = 0;
        prev = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            if (sck && !prev) break;
            prev = sck;
        end
        check("t1_sck_period", n, 2 * C);
        wait_drain(3000, "t1");
        en = 1'b0;
        @(negedge clk);
        check("t1_idle_outputs", {sck, ws, sd}, 3'b000);
        check("t1_no_underrun", ur_cnt - ur0, 0);

        // Back-to-back pairs with in_valid held
        ur0 = ur_cnt;
        l_data = 16'h1478;
        r_data = 16'hA3B9;
        in_valid = 1'b1;
        @(negedge clk);
        l_data = 16'hCDD7;
        r_data = 16'hBABA;
        push_slots(16'h1478, 16'hA3B9, 2 * B);
        push_slots(16'hCDD7, 16'hBABA, 2 * B);
        en = 1'b1;
        @(negedge clk);
        check("t2_ready_after_load", in_ready, 1);
        @(negedge clk);
        check("t2_second_accepted", in_ready, 0);
        in_valid = 1'b0;
        wait_drain(6000, "t2");
        en = 1'b0;
        @(negedge clk);
        check("t2_no_underrun", ur_cnt - ur0, 0);

        // Start with holding empty
        ur0 = ur_cnt;
        push_slots('0, '0, 2 * B);
        en = 1'b1;
        @(negedge clk);
        check("t3_underrun_pulse", underrun, 1);
        @(negedge clk);
        check("t3_underrun_one_cycle", underrun, 0);
        wait_drain(3000, "t3");
        en = 1'b0;
        @(negedge clk);
        check("t3_underrun_count", ur_cnt - ur0, 1);

        // Pair offered in the load cycle goes to the next frame
        ur0 = ur_cnt;
        l_data = 16'h0001;
        r_data = 16'hFFFF;
        in_valid = 1'b1;
        en = 1'b1;
        push_slots('0, '0, 2 * B);
        push_slots(16'h0001, 16'hFFFF, 2 * B);
        @(negedge clk);
        in_valid = 1'b0;
        check("t4_underrun", underrun, 1);
        check("t4_pair_held", in_ready, 0);
        wait_drain(6000, "t4");
        en = 1'b0;
        @(negedge clk);
        check("t4_underrun_count", ur_cnt - ur0, 1);

        // en dropped at slot (1,7), then restart
        ur0 = ur_cnt;
        l_data = 16'h1234;
        r_data = 16'h5678;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        push_slots(16'h1234, 16'h5678, B + 8);
        en = 1'b1;
        wait_drain(2500, "t5a");
        en = 1'b0;
        @(negedge clk);
        check("t5_idle_outputs", {sck, ws, sd}, 3'b000);
        l_data = 16'h9ABC;
        r_data = 16'hDEF0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        push_slots(16'h9ABC, 16'hDEF0, 2 * B);
        en = 1'b1;
        wait_drain(3000, "t5b");
        en = 1'b0;
        @(negedge clk);
        check("t5_no_underrun", ur_cnt - ur0, 0);

        // Asynchronous reset mid-frame loses the holding register
        mon_on = 1'b0;
        l_data = 16'h1111;
        r_data = 16'h2222;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        en = 1'b1;
        repeat (300) @(negedge clk);
        l_data = 16'h3333;
        r_data = 16'h4444;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("t6_hold_full", in_ready, 0);
        repeat (100) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_outputs", {sck, ws, sd, underrun}, 4'b0000);
        check("t6_async_ready", in_ready, 1);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        mon_on = 1'b1;
        ur0 = ur_cnt;
        push_slots('0, '0, 2 * B);
        en = 1'b1;
        @(negedge clk);
        check("t6_hold_lost", underrun, 1);
        wait_drain(3000, "t6");
        en = 1'b0;
        @(negedge clk);
        check("t6_underrun_count", ur_cnt - ur0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
